// File: rtl/vram_arbiter.sv
// vram_arbiter: single-port VRAM arbiter. Scanout reads take absolute priority; two sprite
// writers share spare slots round-robin, gated by a vblank-driven frame-phase FSM.
// Optional macro VRAM_ARB_STATS_EN adds the per-frame write counter output wr_count.

module vram_arbiter #(
  parameter int unsigned ADDR_W       = 17,
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned WR_IN_ACTIVE = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              vblank,
  input  logic              scan_req,
  input  logic [ADDR_W-1:0] scan_addr,
  output logic [DATA_W-1:0] scan_rdata,
  output logic              scan_valid,
  input  logic              w0_req,
  input  logic [ADDR_W-1:0] w0_addr,
  input  logic [DATA_W-1:0] w0_data,
  output logic              w0_ack,
  input  logic              w1_req,
  input  logic [ADDR_W-1:0] w1_addr,
  input  logic [DATA_W-1:0] w1_data,
  output logic              w1_ack,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [1:0]        phase
`ifdef VRAM_ARB_STATS_EN
  ,
  output logic [15:0]       wr_count
`endif
);

  typedef enum logic [1:0] {
    PH_WAIT   = 2'd0,
    PH_ACTIVE = 2'd1,
    PH_VBLANK = 2'd2
  } phase_e;

  localparam bit WrActEn = (WR_IN_ACTIVE != 0);

  phase_e            phase_q, phase_d;
  logic              vblank_q;
  logic              vblank_rise_s, vblank_fall_s;
  logic              wr_elig_s;
  logic              req0_s, req1_s;
  logic              gnt0_s, gnt1_s;
  logic              rr_q, rr_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              mem_we_q, mem_we_d;
  logic              w0_ack_q, w1_ack_q;
  logic              rd_slot_q, scan_valid_q;

  assign vblank_rise_s = vblank & ~vblank_q;
  assign vblank_fall_s = ~vblank & vblank_q;

  // Frame-phase state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      phase_q <= PH_WAIT;
    end else begin
      phase_q <= phase_d;
    end
  end

  // Frame-phase next state; WAIT only leaves on the first vblank so no frame is torn
  always_comb begin
    phase_d = phase_q;
    case (phase_q)
      PH_WAIT: begin
        if (vblank_rise_s) phase_d = PH_VBLANK;
        else               phase_d = PH_WAIT;
      end
      PH_ACTIVE: begin
        if (vblank_rise_s) phase_d = PH_VBLANK;
        else               phase_d = PH_ACTIVE;
      end
      PH_VBLANK: begin
        if (vblank_fall_s) phase_d = PH_ACTIVE;
        else               phase_d = PH_VBLANK;
      end
      default: phase_d = PH_WAIT;
    endcase
  end

  // Writer eligibility decoded from the current phase
  always_comb begin
    wr_elig_s = 1'b0;
    case (phase_q)
      PH_VBLANK: wr_elig_s = 1'b1;
      PH_ACTIVE: wr_elig_s = WrActEn;
      PH_WAIT:   wr_elig_s = 1'b0;
      default:   wr_elig_s = 1'b0;
    endcase
  end

  // A writer being acked this cycle is masked so the same request is never granted twice
  assign req0_s = w0_req & ~w0_ack_q;
  assign req1_s = w1_req & ~w1_ack_q;

  // Write grant: scan always wins, otherwise round-robin between the writers
  always_comb begin
    gnt0_s = 1'b0;
    gnt1_s = 1'b0;
    if (!scan_req && wr_elig_s) begin
      if (req0_s && req1_s) begin
        gnt0_s = ~rr_q;
        gnt1_s = rr_q;
      end else begin
        gnt0_s = req0_s;
        gnt1_s = req1_s;
      end
    end else begin
      gnt0_s = 1'b0;
      gnt1_s = 1'b0;
    end
  end

  // Slot payload and round-robin pointer for the next edge
  always_comb begin
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_we_d    = 1'b0;
    rr_d        = rr_q;
    if (scan_req) begin
      mem_addr_d = scan_addr;
    end else if (gnt0_s) begin
      mem_addr_d  = w0_addr;
      mem_wdata_d = w0_data;
      mem_we_d    = 1'b1;
      rr_d        = 1'b1;
    end else if (gnt1_s) begin
      mem_addr_d  = w1_addr;
      mem_wdata_d = w1_data;
      mem_we_d    = 1'b1;
      rr_d        = 1'b0;
    end else begin
      mem_we_d = 1'b0;
    end
  end

  // Slot registers; reset drops any in-flight slot together with its ack/valid
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vblank_q     <= 1'b0;
      rr_q         <= 1'b0;
      mem_addr_q   <= {ADDR_W{1'b0}};
      mem_wdata_q  <= {DATA_W{1'b0}};
      mem_we_q     <= 1'b0;
      w0_ack_q     <= 1'b0;
      w1_ack_q     <= 1'b0;
      rd_slot_q    <= 1'b0;
      scan_valid_q <= 1'b0;
    end else begin
      vblank_q     <= vblank;
      rr_q         <= rr_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_we_q     <= mem_we_d;
      w0_ack_q     <= gnt0_s;
      w1_ack_q     <= gnt1_s;
      rd_slot_q    <= scan_req;
      scan_valid_q <= rd_slot_q;
    end
  end

  // RAM data arrives one cycle after the address, aligned with scan_valid
  assign scan_rdata = scan_valid_q ? mem_rdata : {DATA_W{1'b0}};
  assign scan_valid = scan_valid_q;
  assign w0_ack     = w0_ack_q;
  assign w1_ack     = w1_ack_q;
  assign mem_addr   = mem_addr_q;
  assign mem_we     = mem_we_q;
  assign mem_wdata  = mem_wdata_q;
  assign phase      = phase_q;

`ifdef VRAM_ARB_STATS_EN
  logic        grant_s;
  logic [15:0] wr_cnt_q, wr_cnt_d;
  logic [15:0] wr_count_q, wr_count_d;

  assign grant_s = gnt0_s | gnt1_s;

  // Saturating per-frame write counter, snapshotted and restarted on vblank fall
  always_comb begin
    wr_cnt_d   = wr_cnt_q;
    wr_count_d = wr_count_q;
    if (vblank_fall_s) begin
      wr_count_d = wr_cnt_q;
      wr_cnt_d   = grant_s ? 16'd1 : 16'd0;
    end else if (grant_s && (wr_cnt_q != 16'hFFFF)) begin
      wr_cnt_d = wr_cnt_q + 16'd1;
    end else begin
      wr_cnt_d = wr_cnt_q;
    end
  end

  // Statistics registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_cnt_q   <= 16'd0;
      wr_count_q <= 16'd0;
    end else begin
      wr_cnt_q   <= wr_cnt_d;
      wr_count_q <= wr_count_d;
    end
  end

  assign wr_count = wr_count_q;
`endif

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed testbench for vram_arbiter: main instance (WR_IN_ACTIVE=1) plus a vblank-only
// instance (WR_IN_ACTIVE=0); wr_count is checked when VRAM_ARB_STATS_EN is defined.

module tb_vram_arbiter;

  logic        clk;
  logic        reset;
  logic        vblank;
  logic        scan_req;
  logic [16:0] scan_addr;
  logic [7:0]  scan_rdata;
  logic        scan_valid;
  logic        w0_req, w1_req;
  logic [16:0] w0_addr, w1_addr;
  logic [7:0]  w0_data, w1_data;
  logic        w0_ack, w1_ack;
  logic [16:0] mem_addr;
  logic        mem_we;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic [1:0]  phase;
`ifdef VRAM_ARB_STATS_EN
  logic [15:0] wr_count;
  logic [15:0] ro_wr_count;
`endif

  logic        ro_w0_req;
  logic [16:0] ro_w0_addr;
  logic [7:0]  ro_w0_data;
  logic        ro_w0_ack, ro_w1_ack;
  logic [7:0]  ro_scan_rdata;
  logic        ro_scan_valid;
  logic [16:0] ro_mem_addr;
  logic        ro_mem_we;
  logic [7:0]  ro_mem_wdata;
  logic [1:0]  ro_phase;

  int n_cmp;
  int n_err;

  vram_arbiter #(.ADDR_W(17), .DATA_W(8), .WR_IN_ACTIVE(1)) u_dut (
    .clk(clk), .reset(reset), .vblank(vblank),
    .scan_req(scan_req), .scan_addr(scan_addr), .scan_rdata(scan_rdata), .scan_valid(scan_valid),
    .w0_req(w0_req), .w0_addr(w0_addr), .w0_data(w0_data), .w0_ack(w0_ack),
    .w1_req(w1_req), .w1_addr(w1_addr), .w1_data(w1_data), .w1_ack(w1_ack),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .phase(phase)
`ifdef VRAM_ARB_STATS_EN
    , .wr_count(wr_count)
`endif
  );

  vram_arbiter #(.ADDR_W(17), .DATA_W(8), .WR_IN_ACTIVE(0)) u_dut_ro (
    .clk(clk), .reset(reset), .vblank(vblank),
    .scan_req(1'b0), .scan_addr(17'd0), .scan_rdata(ro_scan_rdata), .scan_valid(ro_scan_valid),
    .w0_req(ro_w0_req), .w0_addr(ro_w0_addr), .w0_data(ro_w0_data), .w0_ack(ro_w0_ack),
    .w1_req(1'b0), .w1_addr(17'd0), .w1_data(8'd0), .w1_ack(ro_w1_ack),
    .mem_addr(ro_mem_addr), .mem_we(ro_mem_we), .mem_wdata(ro_mem_wdata), .mem_rdata(8'd0),
    .phase(ro_phase)
`ifdef VRAM_ARB_STATS_EN
    , .wr_count(ro_wr_count)
`endif
  );

  always #5 clk = ~clk;

  // RAM model: region 0x003xx returns a fixed pattern, one-cycle read latency
  always @(posedge clk) begin
    mem_rdata <= (mem_addr[16:8] == 9'h003) ? (8'hC0 ^ mem_addr[7:0]) : 8'h00;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] exp_who  [4];
    logic [31:0] exp_addr [4];
    int nw, n0, n1;

    n_cmp = 0; n_err = 0;
    clk = 1'b0; reset = 1'b0; vblank = 1'b0;
    scan_req = 1'b0; scan_addr = 17'd0;
    w0_req = 1'b0; w0_addr = 17'd0; w0_data = 8'd0;
    w1_req = 1'b0; w1_addr = 17'd0; w1_data = 8'd0;
    ro_w0_req = 1'b0; ro_w0_addr = 17'd0; ro_w0_data = 8'd0;

    // Reset state
    repeat (3) step();
    check_eq("rst_phase", 32'(phase), 32'd0);
    check_eq("rst_we", 32'(mem_we), 32'd0);
    check_eq("rst_addr", 32'(mem_addr), 32'd0);
    check_eq("rst_wdata", 32'(mem_wdata), 32'd0);
    check_eq("rst_acks", 32'({w0_ack, w1_ack}), 32'd0);
    check_eq("rst_valid", 32'(scan_valid), 32'd0);
    check_eq("rst_rdata", 32'(scan_rdata), 32'd0);
`ifdef VRAM_ARB_STATS_EN
    check_eq("rst_wr_count", 32'(wr_count), 32'd0);
`endif
    reset = 1'b1;

    // WAIT: a requesting writer is never granted before the first vblank
    w0_req = 1'b1; w0_addr = 17'h00010; w0_data = 8'hAA;
    for (int c = 0; c < 100; c++) begin
      step();
      check_eq("wait_phase", 32'(phase), 32'd0);
      check_eq("wait_ack", 32'(w0_ack), 32'd0);
      check_eq("wait_we", 32'(mem_we), 32'd0);
    end

    // First vblank rise: phase next cycle, write appears two cycles after the rise
    vblank = 1'b1;
    step();
    check_eq("rise_phase", 32'(phase), 32'd2);
    check_eq("rise_we_early", 32'(mem_we), 32'd0);
    check_eq("rise_ack_early", 32'(w0_ack), 32'd0);
    step();
    check_eq("first_we", 32'(mem_we), 32'd1);
    check_eq("first_addr", 32'(mem_addr), 32'h00010);
    check_eq("first_wdata", 32'(mem_wdata), 32'hAA);
    check_eq("first_ack", 32'(w0_ack), 32'd1);
    w0_req = 1'b0;
    step();
    check_eq("first_ack_drop", 32'(w0_ack), 32'd0);
    check_eq("first_we_drop", 32'(mem_we), 32'd0);

    // Both writers, two writes each; pointer points at w1 after the w0 grant above
    exp_who[0] = 32'd1; exp_addr[0] = 32'h200;
    exp_who[1] = 32'd0; exp_addr[1] = 32'h100;
    exp_who[2] = 32'd1; exp_addr[2] = 32'h201;
    exp_who[3] = 32'd0; exp_addr[3] = 32'h101;
    w0_addr = 17'h100; w0_data = 8'h11; w0_req = 1'b1;
    w1_addr = 17'h200; w1_data = 8'h22; w1_req = 1'b1;
    nw = 0; n0 = 0; n1 = 0;
    for (int c = 0; c < 12; c++) begin
      step();
      check_eq("rr_both_ack", 32'(w0_ack & w1_ack), 32'd0);
      if (w0_ack || w1_ack) begin
        if (nw < 4) begin
          check_eq("rr_who", 32'(w1_ack), exp_who[nw]);
          check_eq("rr_addr", 32'(mem_addr), exp_addr[nw]);
          check_eq("rr_we", 32'(mem_we), 32'd1);
        end
        nw++;
        if (w0_ack) begin
          n0++;
          if (n0 == 2) w0_req = 1'b0;
          else begin w0_addr = 17'h101; w0_data = 8'h12; end
        end
        if (w1_ack) begin
          n1++;
          if (n1 == 2) w1_req = 1'b0;
          else begin w1_addr = 17'h201; w1_data = 8'h23; end
        end
      end
    end
    check_eq("rr_total", 32'(nw), 32'd4);

    // vblank fall -> ACTIVE
    vblank = 1'b0;
    step();
    check_eq("fall_phase", 32'(phase), 32'd1);
    check_eq("fall_phase_ro", 32'(ro_phase), 32'd1);

    // ACTIVE: 10 scan reads hold off writer 1, which is acked right after scan drops
    w1_req = 1'b1; w1_addr = 17'h400; w1_data = 8'h77;
    for (int c = 0; c < 14; c++) begin
      scan_req  = (c < 10);
      scan_addr = 17'h300 + 17'(c);
      step();
      if (c < 10) check_eq("scan_addr", 32'(mem_addr), 32'h300 + 32'(c));
      check_eq("scan_valid", 32'(scan_valid), 32'((c >= 1) && (c <= 10)));
      if ((c >= 1) && (c <= 10))
        check_eq("scan_rdata", 32'(scan_rdata), 32'(8'hC0 ^ 8'(c - 1)));
      else
        check_eq("scan_rdata_idle", 32'(scan_rdata), 32'd0);
      check_eq("scan_w1_ack", 32'(w1_ack), 32'(c == 10));
      check_eq("scan_we", 32'(mem_we), 32'(c == 10));
      if (w1_ack) w1_req = 1'b0;
    end
    check_eq("scan_w1_wdata", 32'(mem_wdata), 32'h77);

    // WR_IN_ACTIVE=0: writer waits through ACTIVE until the next vblank rise
    ro_w0_req = 1'b1; ro_w0_addr = 17'h00050; ro_w0_data = 8'h05;
    for (int c = 0; c < 20; c++) begin
      step();
      check_eq("ro_ack_active", 32'(ro_w0_ack), 32'd0);
      check_eq("ro_we_active", 32'(ro_mem_we), 32'd0);
    end
    vblank = 1'b1;
    step();
    check_eq("ro_rise_phase", 32'(ro_phase), 32'd2);
    check_eq("ro_rise_ack", 32'(ro_w0_ack), 32'd0);
    step();
    check_eq("ro_ack", 32'(ro_w0_ack), 32'd1);
    check_eq("ro_we", 32'(ro_mem_we), 32'd1);
    check_eq("ro_addr", 32'(ro_mem_addr), 32'h00050);
    ro_w0_req = 1'b0;

    // Reset while a write is in flight clears it without ack
    w0_req = 1'b1; w0_addr = 17'h123; w0_data = 8'h3C;
    step();
    check_eq("pre_rst_ack", 32'(w0_ack), 32'd1);
    reset  = 1'b0;
    w0_req = 1'b0;
    #1;
    check_eq("mid_rst_we", 32'(mem_we), 32'd0);
    check_eq("mid_rst_ack", 32'(w0_ack), 32'd0);
    check_eq("mid_rst_phase", 32'(phase), 32'd0);
    check_eq("mid_rst_addr", 32'(mem_addr), 32'd0);
    step();
    reset = 1'b1;
    step();
    check_eq("post_rst_ack", 32'(w0_ack), 32'd0);
    check_eq("post_rst_valid", 32'(scan_valid), 32'd0);
    // vblank history restarts at 0, so a held-high vblank reads as a rise
    check_eq("post_rst_phase", 32'(phase), 32'd2);

    // Five writes in one vblank, then vblank fall
    w0_req = 1'b1; w0_addr = 17'h500; w0_data = 8'h01;
    n0 = 0;
    for (int c = 0; c < 20; c++) begin
      step();
      if (w0_ack) begin
        n0++;
        if (n0 == 5) w0_req = 1'b0;
        else begin w0_addr = w0_addr + 17'd1; w0_data = w0_data + 8'd1; end
      end
    end
    check_eq("five_writes", 32'(n0), 32'd5);
`ifdef VRAM_ARB_STATS_EN
    check_eq("cnt_before_fall", 32'(wr_count), 32'd0);
`endif
    vblank = 1'b0;
    step();
    check_eq("five_fall_phase", 32'(phase), 32'd1);
`ifdef VRAM_ARB_STATS_EN
    check_eq("cnt_after_fall", 32'(wr_count), 32'd5);
    reset = 1'b0;
    #1;
    check_eq("cnt_mid_rst", 32'(wr_count), 32'd0);
    step();
    reset = 1'b1;
`endif

    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
